dimming_frame_ctrl: RTL and testbench
=====================================

Name: dimming_frame_ctrl

Overview:
Frame-level scheduler for the local-dimming path. It runs once per video frame:
- waits for zone gray statistics to complete, then starts the 24x15 zone min-filter with a one-cycle pulse;
- captures each filtered light value into the back bank of a ping-pong backlight buffer;
- swaps banks at a driver-safe point, so the LED scan driver always reads a complete, consistent frame.

Parameters:
ZONES, 360, number of backlight zones (24 columns x 15 rows); zone index range 0..ZONES-1
LIGHT_W, 16, width of a filtered light value
TIMEOUT, 8192, maximum cycles allowed in FILTER (nominal filter pass is 17 x 360 = 6120 cycles)
MIN_LIGHT, 16'h0010, floor value used only when DIM_FLOOR_EN is defined

Ports:
sys_clk  in  1  clock
sys_rst  in  1  reset; asynchronous, active-low
frame_start  in  1  one-cycle pulse per frame (vsync-derived)
stat_done  in  1  one-cycle pulse; all zone gray statistics have been written to the filter
process_end  out  1  one-cycle pulse that starts the filter pass
light  in  16  filtered light value from the filter
light_index  in  9  zone index associated with light
get_map  in  1  one-cycle strobe; light and light_index are valid
filter_end  in  1  one-cycle pulse; filter pass complete
swap_ok  in  1  level from the LED driver; high while no scan is in progress
rd_addr  in  9  driver read address (zone index)
rd_data  out  16  front-bank light value; 1-cycle read latency
frame_ready  out  1  one-cycle pulse on each bank swap
front_valid  out  1  high after the first successful swap
err_overrun  out  1  sticky; frame_start arrived while not IDLE
err_timeout  out  1  sticky; FILTER exceeded TIMEOUT, or the write count was not ZONES
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - state IDLE; front bank = 0.
  - process_end, frame_ready, front_valid, err_overrun, err_timeout, busy all 0.
  - rd_data 0; RAM contents are undefined.
- Reset mid-operation aborts the frame: no swap occurs and front_valid returns to 0.
- State machine:
  - IDLE -> WAIT_STATS on frame_start.
  - WAIT_STATS -> FILTER on stat_done. process_end is asserted on the cycle after stat_done. At the same time the write counter and the timeout counter clear.
  - FILTER:
    - Each get_map writes light to the back bank at light_index and increments the write counter.
    - If light_index >= ZONES, no write occurs, the counter does not increment, and err_timeout is set.
    - On filter_end: write counter == ZONES -> SWAP; otherwise set err_timeout and go to IDLE with no swap.
    - If the timeout counter reaches TIMEOUT: set err_timeout and go to IDLE. The back bank is discarded and the front bank is unchanged.
    - If get_map and filter_end occur in the same cycle, the write is performed and counted before the comparison.
  - SWAP: wait for swap_ok = 1. On that cycle toggle the front bank, pulse frame_ready, set front_valid, and go to IDLE.
- frame_start in any non-IDLE state: ignored; err_overrun is set. The frame in flight continues.
- Read port:
  - rd_data = front[rd_addr], registered, available 1 cycle after rd_addr.
  - If front_valid = 0, rd_data = 0.
  - If rd_addr >= ZONES, rd_data = 0.
  - A read on the swap cycle returns the old front bank; the next cycle returns the new one.
- Write-counter and timeout-counter widths must hold ZONES and TIMEOUT with no wrap.
- Sticky error flags clear only on reset.

Optional Feature:
DIM_FLOOR_EN
- Defined: the value written to the back bank is max(light, MIN_LIGHT), so no zone goes fully dark.
- Undefined: light is written unmodified, and MIN_LIGHT is unused.

Decomposition:
- Shared package dimming_pkg holds:
  - ZONE_COLS = 24, ZONE_ROWS = 15, ZONES = 360;
  - ZONE_IDX_W = 9, LIGHT_W = 16;
  - the state enum {IDLE, WAIT_STATS, FILTER, SWAP}.
- One sub-module, light_pingpong_ram:
  - two banks of ZONES x LIGHT_W;
  - one write port into the back bank and one registered read port from the front bank;
  - a bank-select input.
- The controller holds the FSM, counters and flags.

Test Plan:
- Nominal frame: frame_start; stat_done; then 360 get_map strobes writing value = index x 3 in order; then filter_end; swap_ok = 1.
  -> One process_end pulse. frame_ready pulses once. Reading rd_addr = 100 returns 300 one cycle later.
- Swap hold: hold swap_ok = 0 for 50 cycles after filter_end, reading addr 5 throughout.
  -> Data from the previous frame is returned until the swap_ok cycle. frame_ready pulses exactly then.
- Short pass: filter_end after only 359 writes.
  -> err_timeout = 1, no frame_ready, front bank unchanged, state back to IDLE.
- Timeout: stat_done, then no filter_end for 8192 cycles.
  -> err_timeout = 1, busy drops to 0, the next frame runs normally.
- Overrun: frame_start during FILTER.
  -> err_overrun = 1 and the current frame still completes and swaps. Separately, get_map with light_index = 400 -> no write and err_timeout = 1.
- DIM_FLOOR_EN defined: write light = 0 at index 7.
  -> rd_addr 7 returns 16'h0010 after the swap. Without the macro it returns 0.

Source files
------------

// File: rtl/dimming_pkg.sv
// ---------------------------------------------------------------------------
// dimming_pkg
// Shared definitions for the local-dimming frame scheduler.
//   - Zone grid geometry (24 columns x 15 rows = 360 zones)
//   - Index / light value widths
//   - Frame timeout default and the optional light floor value
//   - Controller state enum
//   - floor_light(): clamps a light value to MIN_LIGHT. Only used when the
//     design is built with DIM_FLOOR_EN defined.
// ---------------------------------------------------------------------------
package dimming_pkg;

  localparam int ZONE_COLS  = 24;
  localparam int ZONE_ROWS  = 15;
  localparam int ZONES      = ZONE_COLS * ZONE_ROWS;

  localparam int ZONE_IDX_W = 9;
  localparam int LIGHT_W    = 16;

  // Nominal filter pass is 17 cycles per zone (6120); this leaves headroom.
  localparam int TIMEOUT_CYCLES = 8192;

  localparam logic [LIGHT_W-1:0] MIN_LIGHT = 16'h0010;

  // Write counter must hold ZONES without wrapping.
  localparam int WR_CNT_W = $clog2(ZONES + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_STATS,
    FILTER,
    SWAP
  } dim_state_t;

  function automatic logic [LIGHT_W-1:0] floor_light(input logic [LIGHT_W-1:0] value);
    return (value < MIN_LIGHT) ? MIN_LIGHT : value;
  endfunction

endpackage

// File: rtl/dimming_frame_ctrl_ram.sv
// ---------------------------------------------------------------------------
// light_pingpong_ram
// Ping-pong backlight buffer: two banks of ZONES x LIGHT_W.
// The bank selected by front_sel is the front bank (read by the LED driver);
// the other bank is the back bank (written by the filter capture path).
//
// Ports:
//   sys_clk    in   clock
//   sys_rst    in   asynchronous active-low reset (read register only)
//   front_sel  in   0: bank0 is front / bank1 is back; 1: the reverse
//   wr_en      in   write strobe into the back bank
//   wr_addr    in   zone index for the write (caller guarantees < ZONES)
//   wr_data    in   light value to store
//   rd_en      in   when low the read port returns 0 (no valid frame yet)
//   rd_addr    in   zone index for the read
//   rd_data    out  registered front-bank value, 1-cycle latency;
//                   0 when rd_en is low or rd_addr >= ZONES
//
// Bank contents are not reset; only the read register is.
// ---------------------------------------------------------------------------
module light_pingpong_ram
  import dimming_pkg::*;
(
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  front_sel,
  input  logic                  wr_en,
  input  logic [ZONE_IDX_W-1:0] wr_addr,
  input  logic [LIGHT_W-1:0]    wr_data,
  input  logic                  rd_en,
  input  logic [ZONE_IDX_W-1:0] rd_addr,
  output logic [LIGHT_W-1:0]    rd_data
);

  logic [LIGHT_W-1:0] bank0 [ZONES];
  logic [LIGHT_W-1:0] bank1 [ZONES];

  logic rd_in_range;

  assign rd_in_range = (rd_addr < ZONE_IDX_W'(ZONES));

  // Capture path: writes always land in whichever bank is not being scanned.
  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      if (front_sel) begin
        bank0[wr_addr] <= wr_data;
      end else begin
        bank1[wr_addr] <= wr_data;
      end
    end
  end

  // Driver read path. front_sel is sampled on the same edge as rd_addr, so a
  // read issued on the swap cycle still sees the old front bank.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      rd_data <= '0;
    end else if (rd_en && rd_in_range) begin
      rd_data <= front_sel ? bank1[rd_addr] : bank0[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/dimming_frame_ctrl.sv
// ---------------------------------------------------------------------------
// dimming_frame_ctrl
// Frame-level scheduler for the local-dimming path. Once per frame it waits
// for zone statistics, kicks off the zone min-filter, captures every filtered
// light value into the back bank of a ping-pong buffer, and swaps banks when
// the LED driver reports it is between scans.
//
// Build option:
//   DIM_FLOOR_EN  when defined, captured values are clamped to at least
//                 MIN_LIGHT so no zone goes fully dark. When undefined the
//                 filter value is stored unmodified.
//
// Ports:
//   sys_clk      in   clock
//   sys_rst      in   asynchronous active-low reset
//   frame_start  in   one-cycle pulse per frame
//   stat_done    in   one-cycle pulse; zone statistics complete
//   process_end  out  one-cycle pulse starting the filter pass
//   light        in   filtered light value
//   light_index  in   zone index for light
//   get_map      in   strobe; light / light_index valid
//   filter_end   in   one-cycle pulse; filter pass complete
//   swap_ok      in   level; high while the driver is not scanning
//   rd_addr      in   driver read address
//   rd_data      out  front-bank value, 1-cycle latency
//   frame_ready  out  one-cycle pulse on each bank swap
//   front_valid  out  high once a complete frame has been swapped in
//   err_overrun  out  sticky; frame_start seen while busy
//   err_timeout  out  sticky; filter timeout, bad write count or bad index
//   busy         out  high in any state other than IDLE
// ---------------------------------------------------------------------------
module dimming_frame_ctrl
  import dimming_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_CYCLES
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  frame_start,
  input  logic                  stat_done,
  output logic                  process_end,
  input  logic [LIGHT_W-1:0]    light,
  input  logic [ZONE_IDX_W-1:0] light_index,
  input  logic                  get_map,
  input  logic                  filter_end,
  input  logic                  swap_ok,
  input  logic [ZONE_IDX_W-1:0] rd_addr,
  output logic [LIGHT_W-1:0]    rd_data,
  output logic                  frame_ready,
  output logic                  front_valid,
  output logic                  err_overrun,
  output logic                  err_timeout,
  output logic                  busy
);

  localparam int TO_CNT_W = $clog2(TIMEOUT + 1);

  dim_state_t          state;
  logic                front_sel;
  logic [WR_CNT_W-1:0] wr_cnt;
  logic [TO_CNT_W-1:0] to_cnt;

  logic                idx_ok;
  logic                wr_en;
  logic [WR_CNT_W-1:0] wr_cnt_next;
  logic [LIGHT_W-1:0]  wr_data;

  assign idx_ok = (light_index < ZONE_IDX_W'(ZONES));
  assign wr_en  = (state == FILTER) && get_map && idx_ok;

  // Count includes a write landing on the filter_end cycle, so the
  // completeness check sees it. Saturates so a flood of duplicate writes
  // can never wrap back to a "correct" count.
  assign wr_cnt_next = (wr_en && (wr_cnt != '1)) ? wr_cnt + 1'b1 : wr_cnt;

`ifdef DIM_FLOOR_EN
  assign wr_data = floor_light(light);
`else
  assign wr_data = light;
`endif

  assign busy = (state != IDLE);

  // Frame FSM with registered pulses and sticky flags. Any abort path simply
  // returns to IDLE without touching front_sel, so the back bank contents are
  // discarded and the driver keeps scanning the last good frame.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state       <= IDLE;
      front_sel   <= 1'b0;
      wr_cnt      <= '0;
      to_cnt      <= '0;
      process_end <= 1'b0;
      frame_ready <= 1'b0;
      front_valid <= 1'b0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      process_end <= 1'b0;
      frame_ready <= 1'b0;

      // A new frame arriving mid-flight is dropped; the current one continues.
      if (frame_start && (state != IDLE)) begin
        err_overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (frame_start) begin
            state <= WAIT_STATS;
          end
        end

        WAIT_STATS: begin
          if (stat_done) begin
            state       <= FILTER;
            process_end <= 1'b1;
            wr_cnt      <= '0;
            to_cnt      <= '0;
          end
        end

        FILTER: begin
          wr_cnt <= wr_cnt_next;
          if (get_map && !idx_ok) begin
            err_timeout <= 1'b1;
          end
          if (filter_end) begin
            if (wr_cnt_next == WR_CNT_W'(ZONES)) begin
              state <= SWAP;
            end else begin
              err_timeout <= 1'b1;
              state       <= IDLE;
            end
          end else if (to_cnt == TO_CNT_W'(TIMEOUT)) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        SWAP: begin
          if (swap_ok) begin
            front_sel   <= ~front_sel;
            frame_ready <= 1'b1;
            front_valid <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  light_pingpong_ram u_ram (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .front_sel (front_sel),
    .wr_en     (wr_en),
    .wr_addr   (light_index),
    .wr_data   (wr_data),
    .rd_en     (front_valid),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

endmodule

// File: tb/tb_dimming_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dimming_frame_ctrl
// Self-checking bench for dimming_frame_ctrl. Expected read data is pushed
// to a queue when a read address is driven and retired one cycle later when
// the registered read data appears. Honors DIM_FLOOR_EN for expectations.
// ---------------------------------------------------------------------------
module tb_dimming_frame_ctrl;
  import dimming_pkg::*;

  logic                  sys_clk = 1'b0;
  logic                  sys_rst = 1'b0;
  logic                  frame_start = 1'b0;
  logic                  stat_done = 1'b0;
  logic                  get_map = 1'b0;
  logic                  filter_end = 1'b0;
  logic                  swap_ok = 1'b0;
  logic [LIGHT_W-1:0]    light = '0;
  logic [ZONE_IDX_W-1:0] light_index = '0;
  logic [ZONE_IDX_W-1:0] rd_addr = '0;

  logic                  process_end;
  logic [LIGHT_W-1:0]    rd_data;
  logic                  frame_ready;
  logic                  front_valid;
  logic                  err_overrun;
  logic                  err_timeout;
  logic                  busy;

  dimming_frame_ctrl dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .frame_start (frame_start),
    .stat_done   (stat_done),
    .process_end (process_end),
    .light       (light),
    .light_index (light_index),
    .get_map     (get_map),
    .filter_end  (filter_end),
    .swap_ok     (swap_ok),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_ready (frame_ready),
    .front_valid (front_valid),
    .err_overrun (err_overrun),
    .err_timeout (err_timeout),
    .busy        (busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    string             tag;
    logic [LIGHT_W-1:0] val;
    int                due;
  } exp_t;

  exp_t exp_q[$];

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;
  int pe_cnt   = 0;
  int fr_cnt   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one cycle; count output pulses and retire reads that are due.
  task automatic step();
    exp_t e;
    @(negedge sys_clk);
    cyc++;
    if (process_end) pe_cnt++;
    if (frame_ready) fr_cnt++;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      checkOutput(e.tag, 32'(rd_data), 32'(e.val));
    end
  endtask

  task automatic applyStimulus(input logic fs, input logic sd, input logic gm, input int idx,
                               input logic [LIGHT_W-1:0] val, input logic fe, input logic sok);
    frame_start = fs;
    stat_done   = sd;
    get_map     = gm;
    light_index = ZONE_IDX_W'(idx);
    light       = val;
    filter_end  = fe;
    swap_ok     = sok;
    step();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0);
  endtask

  task automatic issueRead(input int addr, input logic [LIGHT_W-1:0] val, input string tag);
    exp_t e;
    rd_addr = ZONE_IDX_W'(addr);
    e.tag = tag;
    e.val = val;
    e.due = cyc + 1;
    exp_q.push_back(e);
  endtask

  function automatic logic [LIGHT_W-1:0] frame_val(input int base, input int idx);
    return LIGHT_W'(base + idx * 3);
  endfunction

  // What the back bank should hold after writing v.
  function automatic logic [LIGHT_W-1:0] exp_stored(input logic [LIGHT_W-1:0] v);
`ifdef DIM_FLOOR_EN
    return (v < 16'h0010) ? 16'h0010 : v;
`else
    return v;
`endif
  endfunction

  task automatic doReset();
    sys_rst = 1'b0;
    idle(3);
    sys_rst = 1'b1;
    idle(2);
  endtask

  task automatic runFrame(input int base, input int nwrites, input int zero_idx,
                          input bit inject_overrun, input bit inject_bad, input bit do_swap);
    logic [LIGHT_W-1:0] v;
    applyStimulus(1'b1, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, '0, 1'b0, 1'b0);
    for (int i = 0; i < nwrites; i++) begin
      v = (i == zero_idx) ? '0 : frame_val(base, i);
      if (inject_bad && i == 200) begin
        applyStimulus(1'b0, 1'b0, 1'b1, 400, 16'hFFFF, 1'b0, 1'b0);
      end
      applyStimulus(inject_overrun && (i == 100), 1'b0, 1'b1, i, v, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 0, '0, 1'b1, 1'b0);
    if (do_swap) begin
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 1'b1);
    end
    idle(2);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pe0;
    int fr0;
    int n;

    // Reset state
    idle(3);
    checkOutput("rst_process_end", 32'(process_end), 32'd0);
    checkOutput("rst_frame_ready", 32'(frame_ready), 32'd0);
    checkOutput("rst_front_valid", 32'(front_valid), 32'd0);
    checkOutput("rst_err_overrun", 32'(err_overrun), 32'd0);
    checkOutput("rst_err_timeout", 32'(err_timeout), 32'd0);
    checkOutput("rst_busy",        32'(busy),        32'd0);
    checkOutput("rst_rd_data",     32'(rd_data),     32'd0);
    sys_rst = 1'b1;
    idle(2);
    issueRead(0, '0, "rd_before_valid");
    idle(1);

    // Nominal frame: value = index * 3
    pe0 = pe_cnt;
    fr0 = fr_cnt;
    runFrame(0, 360, -1, 1'b0, 1'b0, 1'b1);
    checkOutput("nom_process_end_pulses", 32'(pe_cnt - pe0), 32'd1);
    checkOutput("nom_frame_ready_pulses", 32'(fr_cnt - fr0), 32'd1);
    checkOutput("nom_front_valid", 32'(front_valid), 32'd1);
    checkOutput("nom_busy",        32'(busy),        32'd0);
    checkOutput("nom_err_timeout", 32'(err_timeout), 32'd0);
    checkOutput("nom_err_overrun", 32'(err_overrun), 32'd0);
    issueRead(100, exp_stored(16'd300), "nom_rd100");
    idle(1);
    issueRead(359, exp_stored(16'd1077), "nom_rd359");
    idle(1);
    issueRead(400, '0, "nom_rd_out_of_range");
    idle(1);
    issueRead(0, exp_stored(16'd0), "nom_rd0");
    idle(1);

    // Swap hold: driver busy for 50 cycles after filter_end
    runFrame(1000, 360, -1, 1'b0, 1'b0, 1'b0);
    checkOutput("hold_busy_in_swap", 32'(busy), 32'd1);
    fr0 = fr_cnt;
    for (int i = 0; i < 50; i++) begin
      issueRead(5, exp_stored(frame_val(0, 5)), "hold_rd5_old");
      applyStimulus(1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0);
    end
    checkOutput("hold_no_frame_ready", 32'(fr_cnt - fr0), 32'd0);
    issueRead(5, exp_stored(frame_val(0, 5)), "swap_cycle_rd5_old");
    applyStimulus(1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 1'b1);
    checkOutput("swap_frame_ready", 32'(frame_ready), 32'd1);
    issueRead(5, exp_stored(frame_val(1000, 5)), "after_swap_rd5_new");
    idle(1);
    checkOutput("swap_frame_ready_once", 32'(fr_cnt - fr0), 32'd1);
    idle(2);

    // Short pass: only 359 writes
    fr0 = fr_cnt;
    runFrame(2000, 359, -1, 1'b0, 1'b0, 1'b1);
    checkOutput("short_err_timeout",    32'(err_timeout),   32'd1);
    checkOutput("short_no_frame_ready", 32'(fr_cnt - fr0),  32'd0);
    checkOutput("short_busy",           32'(busy),          32'd0);
    checkOutput("short_front_valid",    32'(front_valid),   32'd1);
    issueRead(100, exp_stored(frame_val(1000, 100)), "short_rd100_unchanged");
    idle(1);
    issueRead(358, exp_stored(frame_val(1000, 358)), "short_rd358_unchanged");
    idle(1);

    // Reset in the middle of a frame
    applyStimulus(1'b1, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0);
    idle(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, i, 16'h7777, 1'b0, 1'b0);
    end
    checkOutput("midrst_busy_before", 32'(busy), 32'd1);
    sys_rst = 1'b0;
    idle(2);
    checkOutput("midrst_busy",        32'(busy),        32'd0);
    checkOutput("midrst_front_valid", 32'(front_valid), 32'd0);
    checkOutput("midrst_err_timeout", 32'(err_timeout), 32'd0);
    sys_rst = 1'b1;
    idle(2);
    issueRead(100, '0, "midrst_rd100_zero");
    idle(1);

    // Timeout: no filter_end
    fr0 = fr_cnt;
    applyStimulus(1'b1, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, '0, 1'b0, 1'b0);
    n = 0;
    while (busy && n < 9000) begin
      idle(1);
      n++;
    end
    checkOutput("to_busy_dropped",  32'(busy),        32'd0);
    checkOutput("to_err_timeout",   32'(err_timeout), 32'd1);
    checkOutput("to_cycles_window", 32'(n >= 8185 && n <= 8200), 32'd1);
    checkOutput("to_no_frame_ready", 32'(fr_cnt - fr0), 32'd0);
    checkOutput("to_front_valid",   32'(front_valid), 32'd0);
    fr0 = fr_cnt;
    runFrame(3000, 360, -1, 1'b0, 1'b0, 1'b1);
    checkOutput("to_next_frame_ready", 32'(fr_cnt - fr0), 32'd1);
    checkOutput("to_next_front_valid", 32'(front_valid),  32'd1);
    issueRead(100, exp_stored(frame_val(3000, 100)), "to_next_rd100");
    idle(1);

    // Overrun: frame_start during FILTER
    doReset();
    fr0 = fr_cnt;
    runFrame(500, 360, -1, 1'b1, 1'b0, 1'b1);
    checkOutput("ovr_err_overrun",   32'(err_overrun),  32'd1);
    checkOutput("ovr_err_timeout",   32'(err_timeout),  32'd0);
    checkOutput("ovr_frame_ready",   32'(fr_cnt - fr0), 32'd1);
    checkOutput("ovr_busy_idle",     32'(busy),         32'd0);
    issueRead(100, exp_stored(frame_val(500, 100)), "ovr_rd100");
    idle(1);

    // Out-of-range light_index: no write, flag set, frame still complete
    doReset();
    fr0 = fr_cnt;
    runFrame(4000, 360, -1, 1'b0, 1'b1, 1'b1);
    checkOutput("bad_err_timeout", 32'(err_timeout),  32'd1);
    checkOutput("bad_err_overrun", 32'(err_overrun),  32'd0);
    checkOutput("bad_frame_ready", 32'(fr_cnt - fr0), 32'd1);
    issueRead(100, exp_stored(frame_val(4000, 100)), "bad_rd100");
    idle(1);

    // Zero light at index 7 (floored when DIM_FLOOR_EN is defined)
    runFrame(0, 360, 7, 1'b0, 1'b0, 1'b1);
    issueRead(7, exp_stored(16'd0), "floor_rd7");
    idle(1);
    issueRead(3, exp_stored(frame_val(0, 3)), "floor_rd3");
    idle(1);
    issueRead(8, exp_stored(frame_val(0, 8)), "floor_rd8");
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
